// File: rtl/irq12_pkg.sv
// Shared constants and helpers for the irq_controller12 register window.
package irq12_pkg;
  localparam int WORD_W  = 12;
  localparam int ADDR_W  = 24;
  localparam int MAX_SRC = 24;

  localparam logic [3:0] IRQ_PENDL  = 4'd0;
  localparam logic [3:0] IRQ_PENDH  = 4'd1;
  localparam logic [3:0] IRQ_MASKL  = 4'd2;
  localparam logic [3:0] IRQ_MASKH  = 4'd3;
  localparam logic [3:0] IRQ_VECL   = 4'd4;
  localparam logic [3:0] IRQ_VECH   = 4'd5;
  localparam logic [3:0] IRQ_ACK    = 4'd6;
  localparam logic [3:0] IRQ_STATUS = 4'd7;
  localparam logic [3:0] IRQ_TRIGL  = 4'd8;
  localparam logic [3:0] IRQ_TRIGH  = 4'd9;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [4:0] lowest_set(input logic [MAX_SRC-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction
endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector for one interrupt request line.
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic src_i,
  output logic level_o,
  output logic rise_o
);
  logic       s1_q;
  logic       s2_q;
  logic       prev_q;
  logic [1:0] warm_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
      warm_q <= 2'd0;
    end else begin
      s1_q   <= src_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
    end
  end

  // Edges are only reported once prev_q holds a genuine post-reset sample,
  // so a line held high through reset release never looks like a new request.
  assign rise_o  = s2_q & ~prev_q & (warm_q == 2'd3);
  assign level_o = s2_q;
endmodule

// File: rtl/irq_controller12.sv
// Memory-mapped prioritising interrupt controller feeding the Processor12 irq vector.
// Optional feature macro IRQ_LEVEL_EN adds TRIGL/TRIGH level-sensitive source selection.
module irq_controller12
  import irq12_pkg::*;
#(
  parameter int                NUM_SRC   = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 24'o77777760,
  parameter int                VEC_SHIFT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_SRC-1:0]  src_irq,
  input  logic [ADDR_W-1:0]   address,
  input  logic                mem_write,
  input  logic [WORD_W-1:0]   wdata,
  output logic [WORD_W-1:0]   rdata,
  output logic                sel,
  output logic [ADDR_W-1:0]   irq
);
  localparam logic [MAX_SRC-1:0] SRC_MASK = 24'((25'd1 << NUM_SRC) - 25'd1);

  logic [MAX_SRC-1:0] level, rise, clr, trig, active;
  logic [MAX_SRC-1:0] pend_q, pend_d, mask_q, mask_d;
  logic [ADDR_W-1:0]  vec_q, vec_d, irq_q, irq_d;
  logic [WORD_W-1:0]  rdata_q, rdata_d;
  logic               wr;
  logic [3:0]         off;
  logic [4:0]         win;

  for (genvar i = 0; i < MAX_SRC; i++) begin : g_src
    if (i < NUM_SRC) begin : g_on
      irq_sync_edge u_sync (
        .clk     (clk),
        .rst     (rst),
        .src_i   (src_irq[i]),
        .level_o (level[i]),
        .rise_o  (rise[i])
      );
    end else begin : g_off
      assign level[i] = 1'b0;
      assign rise[i]  = 1'b0;
    end
  end

  assign sel    = (address[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]);
  assign wr     = mem_write & sel;
  assign off    = address[3:0];
  assign active = pend_q & mask_q;
  assign win    = lowest_set(active);

`ifdef IRQ_LEVEL_EN
  logic [MAX_SRC-1:0] trig_q, trig_d;

  always_comb begin
    trig_d = trig_q;
    if (wr && off == IRQ_TRIGL) trig_d[11:0]  = wdata;
    if (wr && off == IRQ_TRIGH) trig_d[23:12] = wdata;
    trig_d = trig_d & SRC_MASK;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) trig_q <= '0;
    else      trig_q <= trig_d;
  end

  assign trig = trig_q;
`else
  assign trig = '0;
`endif

  always_comb begin
    clr = '0;
    if (wr && off == IRQ_PENDL) clr[11:0]  = wdata;
    if (wr && off == IRQ_PENDH) clr[23:12] = wdata;
    if (wr && off == IRQ_ACK && wdata < 12'(NUM_SRC)) clr[wdata[4:0]] = 1'b1;
    // A fresh edge outranks a same-cycle clear; level sources simply follow the line.
    pend_d = (((rise | (pend_q & ~clr)) & ~trig) | (level & trig)) & SRC_MASK;

    mask_d = mask_q;
    if (wr && off == IRQ_MASKL) mask_d[11:0]  = wdata;
    if (wr && off == IRQ_MASKH) mask_d[23:12] = wdata;
    mask_d = mask_d & SRC_MASK;

    vec_d = vec_q;
    if (wr && off == IRQ_VECL) vec_d[11:0]  = wdata;
    if (wr && off == IRQ_VECH) vec_d[23:12] = wdata;

    irq_d = (|active) ? vec_q + (ADDR_W'(win) << VEC_SHIFT) : '0;
  end

  always_comb begin
    rdata_d = '0;
    if (sel) begin
      case (off)
        IRQ_PENDL:  rdata_d = pend_q[11:0];
        IRQ_PENDH:  rdata_d = pend_q[23:12];
        IRQ_MASKL:  rdata_d = mask_q[11:0];
        IRQ_MASKH:  rdata_d = mask_q[23:12];
        IRQ_VECL:   rdata_d = vec_q[11:0];
        IRQ_VECH:   rdata_d = vec_q[23:12];
        IRQ_STATUS: rdata_d = {|active, 6'b0, win};
`ifdef IRQ_LEVEL_EN
        IRQ_TRIGL:  rdata_d = trig_q[11:0];
        IRQ_TRIGH:  rdata_d = trig_q[23:12];
`endif
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q  <= '0;
      mask_q  <= '0;
      vec_q   <= '0;
      rdata_q <= '0;
      irq_q   <= '0;
    end else begin
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      vec_q   <= vec_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;
endmodule

// File: tb/tb_irq_controller12.sv
// Bench for irq_controller12: directed scenarios plus randomized traffic against a timeline model.
module tb_irq_controller12;
  localparam int          NSRC      = 16;
  localparam logic [23:0] BASE      = 24'o77777760;
  localparam logic [23:0] IDLE_ADDR = 24'o00000100;
  localparam logic [23:0] SMASK     = 24'h00FFFF;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NSRC-1:0]  src_irq = '0;
  logic [23:0]      address = IDLE_ADDR;
  logic             mem_write = 1'b0;
  logic [11:0]      wdata = '0;
  logic [11:0]      rdata;
  logic             sel;
  logic [23:0]      irq;

  int n_checks = 0;
  int n_fail   = 0;

  irq_controller12 #(.NUM_SRC(NSRC), .BASE_ADDR(BASE), .VEC_SHIFT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_irq   (src_irq),
    .address   (address),
    .mem_write (mem_write),
    .wdata     (wdata),
    .rdata     (rdata),
    .sel       (sel),
    .irq       (irq)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [23:0] m_pend, m_mask, m_vec, m_trig, m_irq;
  logic [11:0] m_rdata;
  logic [23:0] samp[$];
  int          edge_n;

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_vec = '0; m_trig = '0; m_irq = '0; m_rdata = '0;
    samp = {24'h0, 24'h0, 24'h0, 24'h0};
    edge_n = 0;
  endtask

  function automatic logic [11:0] model_reg(input logic [3:0] o);
    logic [23:0] act;
    act = m_pend & m_mask;
    case (o)
      4'd0: return m_pend[11:0];
      4'd1: return m_pend[23:12];
      4'd2: return m_mask[11:0];
      4'd3: return m_mask[23:12];
      4'd4: return m_vec[11:0];
      4'd5: return m_vec[23:12];
      4'd7: begin
        for (int i = 0; i < 24; i++) if (act[i]) return {1'b1, 6'b0, 5'(i)};
        return 12'o0;
      end
`ifdef IRQ_LEVEL_EN
      4'd8: return m_trig[11:0];
      4'd9: return m_trig[23:12];
`endif
      default: return 12'o0;
    endcase
  endfunction

  function automatic logic [23:0] model_irq();
    logic [23:0] act;
    act = m_pend & m_mask;
    for (int i = 0; i < 24; i++) if (act[i]) return m_vec + 24'(i * 2);
    return 24'o0;
  endfunction

  // One clock edge of the controller, expressed as a timeline of sampled inputs.
  task automatic model_step();
    logic        s, w, rise_i, clr_i;
    logic [3:0]  o;
    logic [23:0] np, s2v, s3v;
    s = (address[23:4] == BASE[23:4]);
    w = s && mem_write;
    o = address[3:0];
    m_rdata = s ? model_reg(o) : 12'o0;
    m_irq = model_irq();
    edge_n++;
    samp.push_front(24'(src_irq));
    void'(samp.pop_back());
    s2v = samp[2];
    s3v = samp[3];
    np = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (m_trig[i]) np[i] = s2v[i];
      else begin
        rise_i = (edge_n >= 4) && s2v[i] && !s3v[i];
        clr_i = w && ((o == 4'd0 && i < 12 && wdata[i % 12]) ||
                      (o == 4'd1 && i >= 12 && wdata[i % 12]) ||
                      (o == 4'd6 && wdata == 12'(i)));
        np[i] = rise_i || (m_pend[i] && !clr_i);
      end
    end
    if (w) begin
      case (o)
        4'd2: m_mask[11:0]  = wdata;
        4'd3: m_mask[23:12] = wdata;
        4'd4: m_vec[11:0]   = wdata;
        4'd5: m_vec[23:12]  = wdata;
`ifdef IRQ_LEVEL_EN
        4'd8: m_trig[11:0]  = wdata;
        4'd9: m_trig[23:12] = wdata;
`endif
        default: ;
      endcase
    end
    m_mask = m_mask & SMASK;
    m_trig = m_trig & SMASK;
    m_pend = np;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %o expected %o", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("irq", irq, m_irq);
      check("rdata", {12'b0, rdata}, {12'b0, m_rdata});
      check("sel", {23'b0, sel}, {23'b0, address[23:4] == BASE[23:4]});
    end
  end

  // ---------------- drivers ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic bus_write(input logic [3:0] o, input logic [11:0] d);
    address = {BASE[23:4], o};
    mem_write = 1'b1;
    wdata = d;
    cyc();
    mem_write = 1'b0;
    address = IDLE_ADDR;
  endtask

  task automatic bus_read(input logic [3:0] o, output logic [11:0] d);
    address = {BASE[23:4], o};
    mem_write = 1'b0;
    cyc();
    d = rdata;
    address = IDLE_ADDR;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [11:0] d;
    logic [3:0]  ro;
    int          op;
    model_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    check("rst_irq", irq, 24'o0);
    bus_read(4'd0, d); check("rst_pendl", {12'b0, d}, 24'o0);
    bus_read(4'd2, d); check("rst_maskl", {12'b0, d}, 24'o0);
    bus_read(4'd4, d); check("rst_vecl", {12'b0, d}, 24'o0);
    idle(4);

    // single pulse on source 5
    bus_write(4'd2, 12'o7777);
    bus_write(4'd3, 12'o7777);
    src_irq[5] = 1'b1; cyc(); src_irq[5] = 1'b0;
    idle(4);
    bus_read(4'd0, d); check("t1_pendl", {12'b0, d}, 24'o0040);
    check("t1_irq", irq, 24'o00000012);

    // two sources, nonzero vector base, ACK
    bus_write(4'd0, 12'o7777);
    bus_write(4'd4, 12'o0000);
    bus_write(4'd5, 12'o0010);
    src_irq[3] = 1'b1; src_irq[9] = 1'b1; cyc(); src_irq = '0;
    idle(4);
    check("t2_irq", irq, 24'o00100006);
    bus_write(4'd6, 12'd3);
    check("t2_ack_lag", irq, 24'o00100006);
    cyc();
    check("t2_ack_irq", irq, 24'o00100022);

    // masked source stays pending without raising irq
    bus_write(4'd0, 12'o7777);
    bus_write(4'd2, 12'o7773);
    src_irq[2] = 1'b1; cyc(); src_irq[2] = 1'b0;
    idle(4);
    bus_read(4'd0, d); check("t3_pendl", {12'b0, d}, 24'o0004);
    check("t3_irq_masked", irq, 24'o0);
    bus_read(4'd7, d); check("t3_status_none", {12'b0, d}, 24'o0);
    bus_write(4'd2, 12'o7777);
    check("t3_unmask_lag", irq, 24'o0);
    cyc();
    check("t3_unmask_irq", irq, 24'o00100004);
    bus_read(4'd7, d); check("t3_status", {12'b0, d}, 24'o4002);

    // W1C in the same cycle as a new edge: set wins
    bus_write(4'd0, 12'o7777);
    idle(2);
    src_irq[0] = 1'b1; cyc(); cyc();
    bus_write(4'd0, 12'o0001);
    idle(2);
    bus_read(4'd0, d); check("t4_set_wins", {12'b0, d}, 24'o0001);
    src_irq[0] = 1'b0;

    // source held high through reset produces no edge
    src_irq[7] = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(8);
    bus_read(4'd0, d); check("t5_held_high", {12'b0, d}, 24'o0);
    src_irq[7] = 1'b0;
    idle(4);
    src_irq[7] = 1'b1;
    idle(5);
    bus_read(4'd0, d); check("t5_reraise", {12'b0, d}, 24'o0200);
    src_irq[7] = 1'b0;

`ifdef IRQ_LEVEL_EN
    bus_write(4'd0, 12'o7777);
    bus_write(4'd2, 12'o7777);
    bus_write(4'd8, 12'o0020);
    src_irq[4] = 1'b1;
    idle(5);
    check("t6_irq", irq, 24'o00000010);
    bus_write(4'd6, 12'd4);
    idle(2);
    bus_read(4'd0, d); check("t6_ack_level", {12'b0, d}, 24'o0020);
    src_irq[4] = 1'b0;
    idle(4);
    bus_read(4'd0, d); check("t6_drop", {12'b0, d}, 24'o0);
    check("t6_irq_drop", irq, 24'o0);
    bus_write(4'd8, 12'o0000);
`endif

    // randomized traffic
    for (int it = 0; it < 3000; it++) begin
      for (int b = 0; b < NSRC; b++) if ($urandom_range(0, 9) == 0) src_irq[b] = ~src_irq[b];
      op = $urandom_range(0, 9);
      ro = 4'($urandom_range(0, 15));
      mem_write = 1'b0;
      address = IDLE_ADDR;
      if (op <= 2) begin
        address = {BASE[23:4], ro};
        mem_write = 1'b1;
        wdata = (ro == 4'd6) ? 12'($urandom_range(0, 31)) : 12'($urandom);
      end else if (op <= 5) begin
        address = {BASE[23:4], ro};
      end else if (op == 6) begin
        address = 24'($urandom_range(0, 24'o77777757));
        mem_write = 1'b1;
        wdata = 12'($urandom);
      end
      if (it == 1500) rst = 1'b0;
      if (it == 1503) rst = 1'b1;
      cyc();
    end
    mem_write = 1'b0;
    address = IDLE_ADDR;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
